mac_dot_sequencer: RTL
======================

Name: mac_dot_sequencer

Overview:
- Operand-side controller that sits directly upstream of the 4-bit accumulating MAC.
- Buffers incoming (a,b) operand pairs in a small FIFO and issues one pair per cycle to the MAC.
- Detects the end of each vector, captures the MAC accumulator as a dot-product result on a valid/ready output, then clears the MAC for the next vector.
- The MAC has no enable, so idle and bubble cycles are issued as a=0, b=0 and leave the accumulator unchanged.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the per-vector term counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  4  multiplicand.
- in_b  in  4  multiplier.
- in_last  in  1  marks the final term of a vector.
- mac_a  out  4  registered multiplicand to the MAC.
- mac_b  out  4  registered multiplier to the MAC.
- mac_cin  out  1  MAC carry-in; constant 0.
- mac_clr  out  1  registered active-high clear to the MAC reset input.
- mac_result  in  8  MAC accumulator value.
- mac_cout  in  1  MAC adder carry-out (combinational, for the sum about to be registered).
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  8  dot-product result.
- out_ovf  out  1  accumulation overflowed at least once during the vector.
- out_terms  out  CNT_W  number of terms in the vector; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low):
  - FIFO empty, so in_ready=1.
  - mac_a=0, mac_b=0, mac_clr=1, out_valid=0, out_data=0, out_ovf=0, out_terms=0.
  - Internal overflow sticky bit and term counter cleared.
  - State=CLEAR.
- FIFO:
  - Push when in_valid && in_ready at a clock edge.
  - No fall-through: an entry pushed at edge E can pop no earlier than E+1.
  - When full, in_ready=0; there is no push bypass on simultaneous pop.
  - Pushes continue in every state.
- Internal term_vld register: set when mac_a/mac_b hold a real term; otherwise they hold 0.
- ISSUE state:
  - FIFO non-empty at an edge: pop, mac_a/mac_b <= head, term_vld<=1, counter+1.
  - FIFO empty: mac_a/mac_b <= 0, term_vld<=0. This is a bubble and does not change the result.
  - Popped entry has last=1: go to DRAIN.
- Overflow sampling: at every edge where term_vld=1, ovf_sticky |= mac_cout. This edge is also the edge at which the MAC accumulates that term.
- DRAIN: at the next edge, the last term accumulates and cout is sampled; mac_a/mac_b <= 0, term_vld<=0; go to CAPTURE.
- CAPTURE: at the next edge, out_data<=mac_result, out_ovf<=sticky (including the DRAIN sample), out_terms<=counter, out_valid<=1; go to HOLD.
- HOLD:
  - Outputs stay stable while out_ready=0.
  - On out_valid && out_ready: out_valid<=0, mac_clr<=1, sticky and counter cleared; go to CLEAR.
- CLEAR:
  - mac_clr is high for exactly one full cycle; no pop in this state.
  - Next edge: mac_clr<=0; go to ISSUE.
- Latency: the term accepted at edge E0 of a single-term vector gives out_valid=1 after edge E0+3, assuming ISSUE is already active.
- Width rule: the result is 8-bit modulo 256. Overflow is any carry out of the 8-bit MAC adder within a vector.
- Reset mid-operation aborts the vector: all queued terms are dropped, the MAC is cleared via mac_clr, and the next vector starts clean.

Optional Feature:
- Macro: MAC_DOT_SAT_EN.
- Defined: at CAPTURE, out_data<=8'hFF when the sticky overflow bit is set, otherwise mac_result.
- Undefined: out_data is always mac_result (wrapped); out_ovf still reports overflow.

Test Plan:
- Vector (3,5),(2,7),(15,15,last) -> out_data=8'hFE, out_ovf=0, out_terms=3.
- Vector (15,15),(15,15,last) -> out_ovf=1; out_data=8'hC2 without the macro, 8'hFF with MAC_DOT_SAT_EN.
- Hold out_ready=0 for 12 cycles while pushing 6 terms of the next vector -> in_ready=0 after 4 accepted, out_data stable; then out_ready=1 -> mac_clr pulses one cycle and the second vector's result is correct, with no carry-over from the first.
- Same vector as the first scenario with in_valid gaps of 1-3 cycles between terms -> identical out_data=8'hFE, out_terms=3.
- Single term (4,4,last) pushed at E0 with state ISSUE -> out_valid rises after E0+3, out_data=8'h10.
- Assert rst low during ISSUE after 2 of 3 terms -> out_valid=0, mac_clr=1, in_ready=1; after release, vector (1,1,last) -> out_data=8'h01.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Operand-side controller for a 4-bit accumulating MAC. Operand pairs are
//   buffered in a small FIFO and issued one per cycle. At the end of each
//   vector the accumulator is captured as a dot-product result on a
//   valid/ready output, and the MAC is then cleared for the next vector.
//
//   Optional feature: define MAC_DOT_SAT_EN to saturate out_data to 8'hFF
//   when the vector overflowed. Without it, out_data is the wrapped sum.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   operand pair handshake (in_ready = !full)
//   in_a, in_b, in_last operand pair and end-of-vector marker
//   mac_a, mac_b        registered operands to the MAC (0 on bubbles)
//   mac_cin             MAC carry-in, tied to 0
//   mac_clr             registered active-high MAC clear
//   mac_result          MAC accumulator value
//   mac_cout            MAC adder carry-out for the sum about to be registered
//   out_valid/out_ready result handshake
//   out_data            dot-product result
//   out_ovf             accumulation overflowed at least once in the vector
//   out_terms           number of terms in the vector (wraps)
module mac_dot_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic [3:0]       mac_a,
    output logic [3:0]       mac_b,
    output logic             mac_cin,
    output logic             mac_clr,
    input  logic [7:0]       mac_result,
    input  logic             mac_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_terms
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StClear,
        StIssue,
        StDrain,
        StCapture,
        StHold
    } state_t;

    state_t state_q, state_d;

    // FIFO entry layout: {last, a, b}
    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    logic [8:0]       head;

    logic             term_vld_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    assign mac_cin  = 1'b0;

    // Extra pointer bit distinguishes full from empty.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == StIssue) && !empty;
    assign head     = mem[rd_ptr_q[PTR_W-1:0]];
    assign accept   = (state_q == StHold) && out_valid && out_ready;

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {in_last, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear:   state_d = StIssue;
            StIssue:   if (pop && head[8]) state_d = StDrain;
            StDrain:   state_d = StCapture;
            StCapture: state_d = StHold;
            StHold:    if (accept) state_d = StClear;
            default:   state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_a      <= '0;
            mac_b      <= '0;
            mac_clr    <= 1'b1;
            term_vld_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            out_terms  <= '0;
        end else begin
            // The MAC accumulates the held term on this same edge, so its
            // carry-out belongs to that term.
            if (term_vld_q && mac_cout) sticky_q <= 1'b1;

            // One-cycle clear pulse following result acceptance.
            mac_clr <= accept;

            unique case (state_q)
                StIssue: begin
                    if (pop) begin
                        mac_a      <= head[7:4];
                        mac_b      <= head[3:0];
                        term_vld_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end else begin
                        // Bubble: 0*0 leaves the accumulator unchanged.
                        mac_a      <= '0;
                        mac_b      <= '0;
                        term_vld_q <= 1'b0;
                    end
                end
                StDrain: begin
                    mac_a      <= '0;
                    mac_b      <= '0;
                    term_vld_q <= 1'b0;
                end
                StCapture: begin
`ifdef MAC_DOT_SAT_EN
                    out_data  <= sticky_q ? 8'hFF : mac_result;
`else
                    out_data  <= mac_result;
`endif
                    out_ovf   <= sticky_q;
                    out_terms <= cnt_q;
                    out_valid <= 1'b1;
                end
                StHold: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        sticky_q  <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
